// File: rtl/ir_pkg.sv
// Shared types and constants for the NEC IR receiver: FSM state encoding,
// inclusive pulse-width windows (in 10 us ticks), command codes and the
// command-to-drive-mode lookup.
package ir_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEAD_LOW,
        S_LEAD_HIGH,
        S_BIT_LOW,
        S_BIT_HIGH,
        S_CHECK,
        S_REPEAT_STOP
    } ir_state_t;

    // Pulse windows, inclusive, measured in ticks.
    localparam logic [10:0] LEAD_LOW_MIN  = 11'd800;
    localparam logic [10:0] LEAD_LOW_MAX  = 11'd1000;
    localparam logic [10:0] LEAD_HIGH_MIN = 11'd400;
    localparam logic [10:0] LEAD_HIGH_MAX = 11'd500;
    localparam logic [10:0] REPEAT_MIN    = 11'd180;
    localparam logic [10:0] REPEAT_MAX    = 11'd270;
    localparam logic [10:0] BIT_LOW_MIN   = 11'd40;
    localparam logic [10:0] BIT_LOW_MAX   = 11'd72;
    localparam logic [10:0] BIT0_MIN      = 11'd40;
    localparam logic [10:0] BIT0_MAX      = 11'd72;
    localparam logic [10:0] BIT1_MIN      = 11'd140;
    localparam logic [10:0] BIT1_MAX      = 11'd200;

    // Remote command codes that select a drive mode.
    localparam logic [7:0] CMD_STOP    = 8'h1C;
    localparam logic [7:0] CMD_FORWARD = 8'h18;
    localparam logic [7:0] CMD_REVERSE = 8'h52;
    localparam logic [7:0] CMD_LEFT    = 8'h08;
    localparam logic [7:0] CMD_RIGHT   = 8'h5A;
    localparam logic [7:0] CMD_FOLLOW  = 8'h45;

    typedef struct packed {
        logic       hit;
        logic [2:0] mode;
    } cmd_map_t;

    // Map a command byte to a drive mode; hit=0 means "leave mode unchanged".
    function automatic cmd_map_t cmd_to_state(input logic [7:0] cmd);
        cmd_map_t r;
        r.hit  = 1'b1;
        r.mode = 3'd0;
        case (cmd)
            CMD_STOP:    r.mode = 3'd0;
            CMD_FORWARD: r.mode = 3'd1;
            CMD_REVERSE: r.mode = 3'd2;
            CMD_LEFT:    r.mode = 3'd3;
            CMD_RIGHT:   r.mode = 3'd4;
            CMD_FOLLOW:  r.mode = 3'd5;
            default:     r.hit  = 1'b0;
        endcase
        return r;
    endfunction

    // Inclusive window test on a phase count.
    function automatic logic in_window(input logic [10:0] t,
                                       input logic [10:0] lo,
                                       input logic [10:0] hi);
        return (t >= lo) && (t <= hi);
    endfunction

endpackage

// File: rtl/ir_pulse_timer.sv
// Front end of the NEC receiver: 2-FF synchronizer, edge detector, tick
// prescaler and an 11-bit saturating phase counter that restarts on every
// edge of the synchronized IR line.
module ir_pulse_timer #(
    parameter int TICK_DIV = 500
) (
    input  logic        clk,
    input  logic        resend,
    input  logic        rxd,
    output logic        rise,
    output logic        fall,
    output logic [10:0] ticks
);

    logic        sync1;
    logic        sync2;
    logic        prev;
    logic [15:0] presc;
    logic        tick;

    assign tick = (presc == 16'(TICK_DIV - 1));
    assign fall = prev & ~sync2;
    assign rise = ~prev & sync2;

    // Synchronize the idle-high IR line; reset to 1 so no edge is faked.
    always_ff @(posedge clk) begin
        if (resend) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            prev  <= 1'b1;
        end else begin
            sync1 <= rxd;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    // Free-running prescaler producing one tick every TICK_DIV clocks.
    always_ff @(posedge clk) begin
        if (resend || tick) begin
            presc <= 16'd0;
        end else begin
            presc <= presc + 16'd1;
        end
    end

    // Phase length in ticks; cleared on any edge, held at 2047 when stalled.
    always_ff @(posedge clk) begin
        if (resend || rise || fall) begin
            ticks <= 11'd0;
        end else if (tick && (ticks != 11'h7FF)) begin
            ticks <= ticks + 11'd1;
        end
    end

endmodule

// File: rtl/nec_ir_receiver.sv
// NEC IR frame decoder. Measures low/high phase widths of the synchronized
// IR line, shifts 32 data bits LSB-first, validates the complement bytes and
// publishes address/command, drive mode and a toggle flag. Repeat frames
// raise repeat_pulse only after a valid code has been seen.
// Build option: define NEC_STRICT_CHECK_EN to also require the address
// complement byte; otherwise the address byte is accepted unverified
// (extended-NEC remotes).
module nec_ir_receiver
    import ir_pkg::*;
#(
    parameter int TICK_DIV      = 500,
    parameter int TIMEOUT_TICKS = 1100
) (
    input  logic       clk,
    input  logic       resend,
    input  logic       IRDA_RXD,
    output logic       code_valid,
    output logic       repeat_pulse,
    output logic [7:0] ir_addr,
    output logic [7:0] ir_cmd,
    output logic [2:0] state_control,
    output logic       toggle,
    output logic       frame_error
);

    logic        rise;
    logic        fall;
    logic [10:0] ticks;

    ir_state_t   state;
    ir_state_t   state_next;
    logic [31:0] sr;
    logic [4:0]  bit_idx;
    logic        have_code;

    logic        timeout;
    logic        frame_ok;
    cmd_map_t    cmd_map;

    // Actions decoded from the current state and edge events.
    logic        abort;
    logic        accept;
    logic        rep_ok;
    logic        shift_en;
    logic        shift_bit;
    logic        clr_idx;

    ir_pulse_timer #(
        .TICK_DIV (TICK_DIV)
    ) u_timer (
        .clk    (clk),
        .resend (resend),
        .rxd    (IRDA_RXD),
        .rise   (rise),
        .fall   (fall),
        .ticks  (ticks)
    );

    assign timeout = (state != S_IDLE) && (ticks >= 11'(TIMEOUT_TICKS));
    assign cmd_map = cmd_to_state(sr[23:16]);

`ifdef NEC_STRICT_CHECK_EN
    assign frame_ok = (sr[31:24] == ~sr[23:16]) && (sr[15:8] == ~sr[7:0]);
`else
    // Address complement byte is intentionally ignored in this build.
    logic sr_unused;
    assign sr_unused = ^sr[15:8];
    assign frame_ok  = (sr[31:24] == ~sr[23:16]);
`endif

    // FSM state register.
    always_ff @(posedge clk) begin
        if (resend) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: advance on the edge that ends each measured phase.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (fall) state_next = S_LEAD_LOW;
            end
            S_LEAD_LOW: begin
                if (timeout) state_next = S_IDLE;
                else if (rise)
                    state_next = in_window(ticks, LEAD_LOW_MIN, LEAD_LOW_MAX) ? S_LEAD_HIGH : S_IDLE;
            end
            S_LEAD_HIGH: begin
                if (timeout) state_next = S_IDLE;
                else if (fall) begin
                    if (in_window(ticks, LEAD_HIGH_MIN, LEAD_HIGH_MAX))   state_next = S_BIT_LOW;
                    else if (in_window(ticks, REPEAT_MIN, REPEAT_MAX))    state_next = S_REPEAT_STOP;
                    else                                                  state_next = S_IDLE;
                end
            end
            S_BIT_LOW: begin
                if (timeout) state_next = S_IDLE;
                else if (rise)
                    state_next = in_window(ticks, BIT_LOW_MIN, BIT_LOW_MAX) ? S_BIT_HIGH : S_IDLE;
            end
            S_BIT_HIGH: begin
                if (timeout) state_next = S_IDLE;
                else if (fall) begin
                    if (in_window(ticks, BIT0_MIN, BIT0_MAX) || in_window(ticks, BIT1_MIN, BIT1_MAX))
                        state_next = (bit_idx == 5'd31) ? S_CHECK : S_BIT_LOW;
                    else
                        state_next = S_IDLE;
                end
            end
            S_CHECK: begin
                state_next = S_IDLE;
            end
            S_REPEAT_STOP: begin
                if (timeout || rise) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Action decode: aborts, bit shifts, frame acceptance and repeat hits.
    always_comb begin
        abort     = 1'b0;
        accept    = 1'b0;
        rep_ok    = 1'b0;
        shift_en  = 1'b0;
        shift_bit = 1'b0;
        clr_idx   = 1'b0;
        case (state)
            S_LEAD_LOW: begin
                if (timeout) abort = 1'b1;
                else if (rise && !in_window(ticks, LEAD_LOW_MIN, LEAD_LOW_MAX)) abort = 1'b1;
            end
            S_LEAD_HIGH: begin
                if (timeout) abort = 1'b1;
                else if (fall) begin
                    if (in_window(ticks, LEAD_HIGH_MIN, LEAD_HIGH_MAX)) clr_idx = 1'b1;
                    else if (!in_window(ticks, REPEAT_MIN, REPEAT_MAX)) abort = 1'b1;
                end
            end
            S_BIT_LOW: begin
                if (timeout) abort = 1'b1;
                else if (rise && !in_window(ticks, BIT_LOW_MIN, BIT_LOW_MAX)) abort = 1'b1;
            end
            S_BIT_HIGH: begin
                if (timeout) abort = 1'b1;
                else if (fall) begin
                    if (in_window(ticks, BIT0_MIN, BIT0_MAX)) begin
                        shift_en = 1'b1;
                    end else if (in_window(ticks, BIT1_MIN, BIT1_MAX)) begin
                        shift_en  = 1'b1;
                        shift_bit = 1'b1;
                    end else begin
                        abort = 1'b1;
                    end
                end
            end
            S_CHECK: begin
                if (frame_ok) accept = 1'b1;
                else          abort  = 1'b1;
            end
            S_REPEAT_STOP: begin
                if (timeout) abort = 1'b1;
                else if (rise && have_code && in_window(ticks, BIT_LOW_MIN, BIT_LOW_MAX)) rep_ok = 1'b1;
            end
            default: ;
        endcase
    end

    // Data shift register and bit index; bits arrive LSB-first.
    always_ff @(posedge clk) begin
        if (resend) begin
            sr      <= 32'd0;
            bit_idx <= 5'd0;
        end else begin
            if (clr_idx) begin
                bit_idx <= 5'd0;
            end else if (shift_en) begin
                sr      <= {shift_bit, sr[31:1]};
                bit_idx <= bit_idx + 5'd1;
            end
        end
    end

    // Registered outputs: pulses and the data they qualify update together.
    always_ff @(posedge clk) begin
        if (resend) begin
            code_valid    <= 1'b0;
            repeat_pulse  <= 1'b0;
            frame_error   <= 1'b0;
            ir_addr       <= 8'd0;
            ir_cmd        <= 8'd0;
            state_control <= 3'd0;
            toggle        <= 1'b0;
            have_code     <= 1'b0;
        end else begin
            code_valid   <= accept;
            repeat_pulse <= rep_ok;
            frame_error  <= abort;
            if (accept) begin
                ir_addr   <= sr[7:0];
                ir_cmd    <= sr[23:16];
                toggle    <= ~toggle;
                have_code <= 1'b1;
                if (cmd_map.hit) state_control <= cmd_map.mode;
            end
            if (abort) have_code <= 1'b0;
        end
    end

endmodule

// File: tb/tb_nec_ir_receiver.sv
// Self-checking bench for nec_ir_receiver. A behavioural frame-level model
// pushes expected events into a queue; a monitor pops one entry per output
// pulse and compares the published state. Ticks are shortened to one clock.
module tb_nec_ir_receiver;

    localparam int TDIV = 1;
    localparam int GAP  = 100;

    logic       clk = 1'b0;
    logic       resend;
    logic       rxd;
    logic       code_valid;
    logic       repeat_pulse;
    logic       frame_error;
    logic       toggle;
    logic [7:0] ir_addr;
    logic [7:0] ir_cmd;
    logic [2:0] state_control;

    int checks = 0;
    int errors = 0;

    // kind: 1 = code_valid, 2 = repeat_pulse, 3 = frame_error
    typedef struct {
        int         kind;
        logic [7:0] addr;
        logic [7:0] cmd;
        logic [2:0] sc;
        logic       tog;
    } exp_t;

    exp_t q[$];

    logic [7:0] m_addr;
    logic [7:0] m_cmd;
    logic [2:0] m_sc;
    logic       m_tog;
    logic       m_have;
    logic [7:0] codes [6] = '{8'h1C, 8'h18, 8'h52, 8'h08, 8'h5A, 8'h45};

    nec_ir_receiver #(
        .TICK_DIV      (TDIV),
        .TIMEOUT_TICKS (1100)
    ) dut (
        .clk           (clk),
        .resend        (resend),
        .IRDA_RXD      (rxd),
        .code_valid    (code_valid),
        .repeat_pulse  (repeat_pulse),
        .ir_addr       (ir_addr),
        .ir_cmd        (ir_cmd),
        .state_control (state_control),
        .toggle        (toggle),
        .frame_error   (frame_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // ---------------- reference model ----------------
    task automatic model_reset();
        m_addr = 8'd0; m_cmd = 8'd0; m_sc = 3'd0; m_tog = 1'b0; m_have = 1'b0;
    endtask

    task automatic push(input int kind);
        exp_t e;
        e.kind = kind; e.addr = m_addr; e.cmd = m_cmd; e.sc = m_sc; e.tog = m_tog;
        q.push_back(e);
    endtask

    task automatic model_frame(input logic [7:0] b0, input logic [7:0] b1,
                               input logic [7:0] b2, input logic [7:0] b3);
        bit ok;
        bit addr_ok;
        ok      = (b3 == ~b2);
        addr_ok = (b1 == ~b0);
`ifdef NEC_STRICT_CHECK_EN
        ok = ok && addr_ok;
`else
        if (!addr_ok) $display("note: address complement mismatch accepted (non-strict build)");
`endif
        if (ok) begin
            m_addr = b0; m_cmd = b2; m_tog = ~m_tog; m_have = 1'b1;
            for (int i = 0; i < 6; i++)
                if (codes[i] == b2) m_sc = 3'(i);
            push(1);
        end else begin
            m_have = 1'b0;
            push(3);
        end
    endtask

    task automatic model_abort();
        m_have = 1'b0;
        push(3);
    endtask

    // ---------------- stimulus ----------------
    function automatic int jit(input int n, input bit en);
        if (!en) return 0;
        return int'($urandom_range(2 * n, 0)) - n;
    endfunction

    task automatic phase(input logic level, input int n);
        rxd = level;
        repeat (n * TDIV) @(negedge clk);
    endtask

    task automatic send_head(input logic [31:0] w, input int nbits, input bit en);
        phase(1'b0, 900 + jit(8, en));
        phase(1'b1, 450 + jit(8, en));
        for (int i = 0; i < nbits; i++) begin
            phase(1'b0, 56 + jit(4, en));
            phase(1'b1, w[i] ? 169 + jit(4, en) : 56 + jit(4, en));
        end
    endtask

    task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2, input logic [7:0] b3, input bit en);
        model_frame(b0, b1, b2, b3);
        send_head({b3, b2, b1, b0}, 32, en);
        phase(1'b0, 56);
        phase(1'b1, GAP);
    endtask

    task automatic send_repeat(input bit en);
        if (m_have) push(2);
        phase(1'b0, 900 + jit(8, en));
        phase(1'b1, 225 + jit(8, en));
        phase(1'b0, 56 + jit(4, en));
        phase(1'b1, GAP);
    endtask

    task automatic random_frame(input bit force_good);
        logic [7:0] a, c, na, nc;
        a  = 8'($urandom);
        c  = ($urandom_range(1, 0) == 1) ? codes[$urandom_range(5, 0)] : 8'($urandom);
        na = ~a;
        nc = ~c;
        if (!force_good && $urandom_range(3, 0) == 0) na = na ^ 8'(1 << $urandom_range(7, 0));
        if (!force_good && $urandom_range(3, 0) == 0) nc = nc ^ 8'(1 << $urandom_range(7, 0));
        send_frame(a, na, c, nc, 1'b1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_code_valid"},    32'(code_valid),    32'd0);
        check({tag, "_repeat_pulse"},  32'(repeat_pulse),  32'd0);
        check({tag, "_frame_error"},   32'(frame_error),   32'd0);
        check({tag, "_ir_addr"},       32'(ir_addr),       32'd0);
        check({tag, "_ir_cmd"},        32'(ir_cmd),        32'd0);
        check({tag, "_state_control"}, 32'(state_control), 32'd0);
        check({tag, "_toggle"},        32'(toggle),        32'd0);
    endtask

    // ---------------- monitor ----------------
    exp_t mon_e;
    int   mon_kind;

    // Pop one expectation per output pulse and compare published state.
    always @(negedge clk) begin
        if (!resend && (code_valid || repeat_pulse || frame_error)) begin
            check("pulse_exclusive", 32'(int'(code_valid) + int'(repeat_pulse) + int'(frame_error)), 32'd1);
            mon_kind = code_valid ? 1 : (repeat_pulse ? 2 : 3);
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_event: got kind %0d, expected no event", mon_kind);
            end else begin
                mon_e = q.pop_front();
                check("event_kind",    32'(mon_kind),      32'(mon_e.kind));
                check("ir_addr",       32'(ir_addr),       32'(mon_e.addr));
                check("ir_cmd",        32'(ir_cmd),        32'(mon_e.cmd));
                check("state_control", 32'(state_control), 32'(mon_e.sc));
                check("toggle",        32'(toggle),        32'(mon_e.tog));
            end
        end
    end

    // ---------------- test sequence ----------------
    initial begin
        logic [31:0] w;
        resend = 1'b1;
        rxd    = 1'b1;
        repeat (4) @(negedge clk);
        resend = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_all_zero("reset");

        // Repeat frame before any valid code: silent.
        send_repeat(1'b1);

        // Ideal frame, addr 0x00 cmd 0x18.
        send_frame(8'h00, 8'hFF, 8'h18, 8'hE7, 1'b0);
        check("first_toggle", 32'(toggle), 32'd1);
        check("first_mode",   32'(state_control), 32'd1);
        check("first_cmd",    32'(ir_cmd), 32'h18);

        // Valid cmd 0x5A followed by a repeat frame.
        send_frame(8'h20, 8'hDF, 8'h5A, 8'hA5, 1'b1);
        send_repeat(1'b1);
        check("repeat_mode_held", 32'(state_control), 32'd4);

        // Bad command complement, then bad address complement.
        send_frame(8'h31, 8'hCE, 8'h52, 8'h00, 1'b1);
        send_frame(8'h12, 8'h00, 8'h08, 8'hF7, 1'b1);

        // Bit-high phase of 100 ticks (between the bit windows).
        w = $urandom;
        model_abort();
        send_head(w, 10, 1'b1);
        phase(1'b0, 56);
        phase(1'b1, 100);
        phase(1'b0, 56);
        phase(1'b1, GAP);

        // Stall mid-frame with the line high for 1200 ticks.
        w = $urandom;
        model_abort();
        send_head(w, 20, 1'b1);
        phase(1'b0, 56);
        phase(1'b1, 1200);
        phase(1'b1, GAP);

        // Recovery: next good frame decodes.
        random_frame(1'b1);

        // Reset during bit 15.
        w = $urandom;
        send_head(w, 15, 1'b1);
        phase(1'b0, 56);
        phase(1'b1, 20);
        resend = 1'b1;
        @(negedge clk);
        resend = 1'b0;
        model_reset();
        phase(1'b1, 5);
        check_all_zero("midreset");
        phase(1'b1, GAP);

        // Clean frame after reset, cmd 0x45.
        send_frame(8'h07, 8'hF8, 8'h45, 8'hBA, 1'b1);
        check("follow_mode", 32'(state_control), 32'd5);

        // Random frame plus repeat.
        random_frame(1'b0);
        send_repeat(1'b1);

        phase(1'b1, GAP);
        check("queue_drained", 32'(q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
